// File: rtl/div_ctrl_if.sv
// div_ctrl_if: bundle of the execute-stage request/result signals and the
// divider issue/collect signals seen by div_ctrl.
//
// Handshake semantics (one rule for the whole bundle):
//   - A request transfers in the cycle where req_valid=1, req_op is one-hot
//     and stall=0. The execute stage holds req_* stable while stall=1.
//   - result_valid is a single-cycle strobe; result is 0 whenever it is low.
//   - div_enable is a single-cycle start pulse; div_op/div_rdata* are only
//     meaningful in that cycle. div_ready is a single-cycle completion strobe
//     and div_result is meaningful only while div_ready=1.
//   - flush overrides everything: no issue and no result in a flush cycle.
//
// The slave modport is the controller; the master modport is its environment
// (execute stage plus divider).
interface div_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [3:0]      req_op;
    logic [XLEN-1:0] req_rdata1;
    logic [XLEN-1:0] req_rdata2;
    logic            flush;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic            div_enable;
    logic [XLEN-1:0] div_rdata1;
    logic [XLEN-1:0] div_rdata2;
    logic [3:0]      div_op;
    logic            div_ready;
    logic [XLEN-1:0] div_result;

    modport slave (
        input  req_valid, req_op, req_rdata1, req_rdata2, flush,
        input  div_ready, div_result,
        output stall, result_valid, result,
        output div_enable, div_rdata1, div_rdata2, div_op
    );

    modport master (
        output req_valid, req_op, req_rdata1, req_rdata2, flush,
        output div_ready, div_result,
        input  stall, result_valid, result,
        input  div_enable, div_rdata1, div_rdata2, div_op
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: issue/collect controller for the iterative divider.
// Accepts one one-hot {remu, rem, divu, divs} request at a time, pulses the
// divider enable for exactly one cycle, stalls the execute stage until the
// divider's ready strobe and hands back the result combinationally.
// A flush never aborts the divider (it has no kill input); a flushed
// operation is drained in DRAIN and its result dropped.
//
// Optional feature: define DIV_CACHE_EN to add a one-entry result cache
// (valid, tag {op, rdata1, rdata2}, data) that answers an exact repeat of the
// last delivered request in its request cycle without touching the divider.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic       clock,
    input  logic       reset,      // synchronous, active-low
    div_ctrl_if.slave  bus,
    output logic [1:0] state_dbg   // current FSM state (IDLE=0, BUSY=1, DRAIN=2)
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // A request counts only when exactly one op bit is set.
    logic req_ok;
    // Issue/deliver decisions made by the output logic, reused by the
    // cache registers so both always agree.
    logic issue;
    logic deliver;
    logic cache_hit;
    logic [XLEN-1:0] hit_data;

    assign req_ok    = bus.req_valid && $onehot(bus.req_op);
    assign state_dbg = state;

`ifdef DIV_CACHE_EN
    // Tag of the operation currently in the divider.
    logic [3:0]      tag_op;
    logic [XLEN-1:0] tag_rdata1;
    logic [XLEN-1:0] tag_rdata2;
    // Last delivered, non-flushed completion.
    logic            cache_valid;
    logic [3:0]      cache_op;
    logic [XLEN-1:0] cache_rdata1;
    logic [XLEN-1:0] cache_rdata2;
    logic [XLEN-1:0] cache_data;

    // Hit only on an exact match of op and both operands.
    assign cache_hit = cache_valid
                    && (cache_op     == bus.req_op)
                    && (cache_rdata1 == bus.req_rdata1)
                    && (cache_rdata2 == bus.req_rdata2);
    assign hit_data  = cache_data;

    // Latch the tag on issue; fill the cache only when a result is delivered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cache_valid <= 1'b0;
        end else begin
            if (issue) begin
                tag_op     <= bus.req_op;
                tag_rdata1 <= bus.req_rdata1;
                tag_rdata2 <= bus.req_rdata2;
            end
            if (deliver) begin
                cache_valid  <= 1'b1;
                cache_op     <= tag_op;
                cache_rdata1 <= tag_rdata1;
                cache_rdata2 <= tag_rdata2;
                cache_data   <= bus.div_result;
            end
        end
    end
`else
    // No cache: every valid request in IDLE goes to the divider.
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // State register; the divider shares this reset, so no drain is needed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a flush only matters while the divider is busy.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.div_ready) begin
                    state_next = ST_IDLE;
                end else if (bus.flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.div_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: all handshake outputs are combinational from state and
    // inputs, and all of them are held at 0 while reset is asserted.
    always_comb begin
        bus.stall        = 1'b0;
        bus.result_valid = 1'b0;
        bus.result       = '0;
        bus.div_enable   = 1'b0;
        bus.div_op       = 4'd0;
        bus.div_rdata1   = '0;
        bus.div_rdata2   = '0;
        issue            = 1'b0;
        deliver          = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (req_ok && !bus.flush) begin
                        if (cache_hit) begin
                            bus.result_valid = 1'b1;
                            bus.result       = hit_data;
                        end else begin
                            issue          = 1'b1;
                            bus.div_enable = 1'b1;
                            bus.stall      = 1'b1;
                            bus.div_op     = bus.req_op;
                            bus.div_rdata1 = bus.req_rdata1;
                            bus.div_rdata2 = bus.req_rdata2;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.div_ready) begin
                        // A flush in the ready cycle drops the result.
                        if (!bus.flush) begin
                            deliver          = 1'b1;
                            bus.result_valid = 1'b1;
                            bus.result       = bus.div_result;
                        end
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // A new request must wait until the cycle after div_ready,
                    // since the divider ignores enable in its ready cycle.
                    bus.stall = bus.req_valid;
                end
                default: begin
                    bus.stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl (builds with or without
// DIV_CACHE_EN). Contains a behavioural divider that answers each enable
// after the documented latency, plus a request-level reference model.
`timescale 1ns/1ps
module tb_div_ctrl;
    localparam int XLEN = 32;
    localparam logic [3:0] OP_DIVS = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_REM  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b1000;
`ifdef DIV_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [1:0] state_dbg;
    always #5 clock = ~clock;

    div_ctrl_if #(.XLEN(XLEN)) bus();
    div_ctrl #(.XLEN(XLEN)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIVS: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider latency: 1 for divide-by-zero, otherwise 33 minus leading zeros.
    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
        int lz;
        if (b == 0) return 1;
        lz = 32;
        for (int i = 31; i >= 0; i--) begin
            if (a[i]) begin
                lz = 31 - i;
                break;
            end
        end
        return 33 - lz;
    endfunction

    // ---------------- behavioural divider ----------------
    int unsigned dv_cnt = 0;
    logic [31:0] dv_res = 0;
    int n_issue = 0;
    int extra_issue = 0;
    always @(posedge clock) begin
        logic en_s;
        logic rst_s;
        logic [3:0] op_s;
        logic [31:0] a_s;
        logic [31:0] b_s;
        en_s  = bus.div_enable;
        rst_s = reset;
        op_s  = bus.div_op;
        a_s   = bus.div_rdata1;
        b_s   = bus.div_rdata2;
        #1;
        bus.div_ready  = 1'b0;
        bus.div_result = $urandom;   // junk when not ready
        if (!rst_s) begin
            dv_cnt = 0;
        end else begin
            if (en_s) begin
                n_issue++;
                if (dv_cnt != 0) extra_issue++;
                dv_cnt = lat_of(a_s, b_s);
                dv_res = ref_div(op_s, a_s, b_s);
            end
            if (dv_cnt > 0) begin
                dv_cnt--;
                if (dv_cnt == 0) begin
                    bus.div_ready  = 1'b1;
                    bus.div_result = dv_res;
                end
            end
        end
    end

    // ---------------- request-level model (cache) ----------------
    logic        m_v = 1'b0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    function automatic bit exp_hit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return CACHE_ON && m_v && (m_op == op) && (m_a == a) && (m_b == b);
    endfunction

    // ---------------- driver tasks ----------------
    // Present a request (starting just after a rising edge) and hold it until
    // stall drops; reports result, cycles until result and enables seen.
    task automatic run_req(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic got, output logic [31:0] res, output int lat, output int n_en);
        got  = 1'b0;
        res  = 32'd0;
        lat  = 0;
        n_en = 0;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_rdata1 = a;
        bus.req_rdata2 = b;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (bus.div_enable) begin
                n_en++;
                check({name, " div_op"}, 32'(bus.div_op), 32'(op));
                check({name, " div_rdata1"}, bus.div_rdata1, a);
                check({name, " div_rdata2"}, bus.div_rdata2, b);
            end
            if (bus.result_valid) begin
                got = 1'b1;
                res = bus.result;
                break;
            end
            if (!bus.stall) break;
            @(posedge clock);
            #1;
            lat++;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
    endtask

    // Run one request and score result, latency and issue count.
    // extra_wait: cycles spent draining a flushed operation first.
    task automatic apply(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int extra_wait);
        bit hit;
        int exp_lat;
        logic got;
        logic [31:0] res;
        int lat;
        int n_en;
        hit = exp_hit(op, a, b);
        exp_lat = hit ? 0 : (extra_wait + lat_of(a, b));
        exp_q.push_back(exp);
        run_req(name, op, a, b, got, res, lat, n_en);
        check({name, " result_valid"}, 32'(got), 32'd1);
        check({name, " result"}, res, exp_q.pop_front());
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " issues"}, 32'(n_en), hit ? 32'd0 : 32'd1);
        if (got) begin
            m_v  = 1'b1;
            m_op = op;
            m_a  = a;
            m_b  = b;
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Check the four handshake outputs at the next falling edge.
    task automatic check_quiet(input string name);
        @(negedge clock);
        check({name, " stall"}, 32'(bus.stall), 32'd0);
        check({name, " result_valid"}, 32'(bus.result_valid), 32'd0);
        check({name, " div_enable"}, 32'(bus.div_enable), 32'd0);
        check({name, " result"}, bus.result, 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];
    logic [3:0] bad_ops[4];

    initial begin : main
        int base;
        int fl_lat;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0] p_op;
        logic [31:0] p_a;
        logic [31:0] p_b;

        tbl[0]  = '{"divu 100/7",      OP_DIVU, 32'd100,        32'd7,          32'd14};
        tbl[1]  = '{"remu 100/7",      OP_REMU, 32'd100,        32'd7,          32'd2};
        tbl[2]  = '{"divs -100/7",     OP_DIVS, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
        tbl[3]  = '{"rem -100/7",      OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
        tbl[4]  = '{"divs ovf",        OP_DIVS, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        tbl[5]  = '{"rem ovf",         OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        tbl[6]  = '{"divu 5/0",        OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        tbl[7]  = '{"remu 5/0",        OP_REMU, 32'd5,          32'd0,          32'd5};
        tbl[8]  = '{"divs 5/0",        OP_DIVS, 32'd5,          32'd0,          32'hFFFF_FFFF};
        tbl[9]  = '{"divu 0/3",        OP_DIVU, 32'd0,          32'd3,          32'd0};
        tbl[10] = '{"divu max/1",      OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        bad_ops[0] = 4'b0000;
        bad_ops[1] = 4'b0011;
        bad_ops[2] = 4'b1111;
        bad_ops[3] = 4'b0101;

        // Reset with a valid request pending: everything must stay quiet.
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rdata1 = 32'd100;
        bus.req_rdata2 = 32'd7;
        bus.flush      = 1'b0;
        reset          = 1'b0;
        check_quiet("reset");
        @(negedge clock);
        check("reset div_op", 32'(bus.div_op), 32'd0);
        check("reset state", 32'(state_dbg), 32'd0);
        step();
        reset = 1'b1;
        bus.req_valid = 1'b0;

        // Table-driven directed vectors.
        foreach (tbl[i]) begin
            apply(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
        end

        // Malformed op encodings are ignored.
        foreach (bad_ops[i]) begin
            bus.req_valid  = 1'b1;
            bus.req_op     = bad_ops[i];
            bus.req_rdata1 = 32'd100;
            bus.req_rdata2 = 32'd7;
            check_quiet("bad op");
            step();
        end
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        check_quiet("idle");
        step();

        // Repeat of an identical request: hit with cache, reissue without.
        apply("divu 100/7 a", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
        apply("divu 100/7 b", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
        apply("remu 100/7 c", OP_REMU, 32'd100, 32'd7, 32'd2, 0);

        // Flush two cycles after issue; the next request waits for the drain.
        fl_lat = lat_of(32'hFFFF_FFFF, 32'd3);
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rdata1 = 32'hFFFF_FFFF;
        bus.req_rdata2 = 32'd3;
        @(negedge clock);
        check("flush issue en", 32'(bus.div_enable), 32'd1);
        step();
        @(negedge clock);
        check("flush busy stall", 32'(bus.stall), 32'd1);
        check("flush busy en", 32'(bus.div_enable), 32'd0);
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clock);
        check("flush cycle result_valid", 32'(bus.result_valid), 32'd0);
        step();
        bus.flush = 1'b0;
        apply("after flush divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, fl_lat - 3 + 1);

        // Flush in the ready cycle: result dropped and not cached.
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rdata1 = 32'd7;
        bus.req_rdata2 = 32'd0;
        @(negedge clock);
        check("flush@ready issue", 32'(bus.div_enable), 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clock);
        check("flush@ready result_valid", 32'(bus.result_valid), 32'd0);
        step();
        bus.flush = 1'b0;
        apply("divu 7/0 reissue", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);

        // Flush in IDLE alongside a request that would hit or issue.
        base = n_issue;
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rdata1 = 32'd7;
        bus.req_rdata2 = 32'd0;
        bus.flush      = 1'b1;
        check_quiet("flush idle");
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        step();
        check("flush idle no issue", 32'(n_issue - base), 32'd0);

        // Reset while BUSY.
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rdata1 = 32'hFFFF_FFFF;
        bus.req_rdata2 = 32'd1;
        @(negedge clock);
        check("rst-busy issue", 32'(bus.div_enable), 32'd1);
        step();
        step();
        reset = 1'b0;
        check_quiet("in reset");
        step();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("post reset stall", 32'(bus.stall), 32'd0);
        check("post reset result_valid", 32'(bus.result_valid), 32'd0);
        check("post reset state", 32'(state_dbg), 32'd0);
        step();
        m_v = 1'b0;
        apply("post reset divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
        apply("post reset divu 100/7 again", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);

        // Randomized requests against the reference model.
        p_op = OP_DIVU;
        p_a  = 32'd100;
        p_b  = 32'd7;
        for (int i = 0; i < 60; i++) begin
            op = 4'b0001 << $urandom_range(0, 3);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: begin op = p_op; a = p_a; b = p_b; end
                1: b = 32'd0;
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: begin end
            endcase
            apply("random", op, a, b, ref_div(op, a, b), 0);
            p_op = op;
            p_a  = a;
            p_b  = b;
            repeat ($urandom_range(0, 2)) step();
        end

        check("no issue while busy", 32'(extra_issue), 32'd0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
